// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between instruction fetch and data
// access, one transaction at a time, with data priority. Registered bus
// handshake, done pulses and read data; combinational stall levels.
// Optional fetch anti-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_flush,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_done,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_done,
   output logic                bus_req,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_wstrb,
   input  logic                bus_ack,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                stall_if,
   output logic                stall_mem
);

   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY_I,
      S_BUSY_D,
      S_BUSY_I_KILL
   } state_t;

   state_t              r_state;
   logic                r_bus_req;
   logic                r_bus_we;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic [DATA_W-1:0]   r_bus_wdata;
   logic [STRB_W-1:0]   r_bus_wstrb;
   logic [DATA_W-1:0]   r_if_rdata;
   logic                r_if_done;
   logic [DATA_W-1:0]   r_d_rdata;
   logic                r_d_done;

   logic                w_fetch_ok;
   logic                w_force_fetch;

   assign w_fetch_ok = if_req && !if_flush;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] r_starve_cnt;

   assign w_force_fetch = (r_starve_cnt == CNT_W'(STARVE_MAX)) && d_req && w_fetch_ok;

   // Count data grants made while fetch waits; any fetch grant or idle-fetch data grant clears
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         if (d_req && !w_force_fetch) begin
            r_starve_cnt <= w_fetch_ok ? r_starve_cnt + 1'b1 : '0;
         end else if (w_fetch_ok) begin
            r_starve_cnt <= '0;
         end
      end
   end
`else
   logic w_unused_starve_max;

   assign w_force_fetch       = 1'b0;
   assign w_unused_starve_max = (STARVE_MAX != 0);
`endif

   // Grant, bus handshake and response capture; done outputs pulse for one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_wstrb <= '0;
         r_if_rdata  <= '0;
         r_if_done   <= 1'b0;
         r_d_rdata   <= '0;
         r_d_done    <= 1'b0;
      end else begin
         r_if_done <= 1'b0;
         r_d_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (d_req && !w_force_fetch) begin
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= d_we;
                  r_bus_addr  <= d_addr;
                  r_bus_wdata <= d_wdata;
                  r_bus_wstrb <= d_wstrb;
                  r_state     <= S_BUSY_D;
               end else if (w_fetch_ok) begin
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= 1'b0;
                  r_bus_addr  <= if_addr;
                  r_bus_wdata <= '0;
                  r_bus_wstrb <= '0;
                  r_state     <= S_BUSY_I;
               end
            end
            S_BUSY_D: begin
               if (bus_ack) begin
                  r_bus_req <= 1'b0;
                  r_d_rdata <= bus_rdata;
                  r_d_done  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            S_BUSY_I: begin
               if (bus_ack) begin
                  r_bus_req <= 1'b0;
                  r_state   <= S_IDLE;
                  if (!if_flush) begin
                     r_if_rdata <= bus_rdata;
                     r_if_done  <= 1'b1;
                  end
               end else if (if_flush) begin
                  r_state <= S_BUSY_I_KILL;
               end
            end
            S_BUSY_I_KILL: begin
               if (bus_ack) begin
                  r_bus_req <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_bus_req <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign bus_wstrb = r_bus_wstrb;
   assign if_rdata  = r_if_rdata;
   assign if_done   = r_if_done;
   assign d_rdata   = r_d_rdata;
   assign d_done    = r_d_done;

   assign stall_if  = if_req && !r_if_done && !if_flush;
   assign stall_mem = d_req && !r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// requester/slave traffic, checked against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int unsigned AW   = 64;
   localparam int unsigned DW   = 64;
   localparam int unsigned SW   = DW / 8;
   localparam int unsigned SMAX = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic [DW-1:0] if_rdata;
   logic          if_done;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [SW-1:0] d_wstrb;
   logic [DW-1:0] d_rdata;
   logic          d_done;
   logic          bus_req;
   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic [SW-1:0] bus_wstrb;
   logic          bus_ack;
   logic [DW-1:0] bus_rdata;
   logic          stall_if;
   logic          stall_mem;

   mem_port_arbiter #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .STARVE_MAX(SMAX)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_flush (if_flush),
      .if_rdata (if_rdata),
      .if_done  (if_done),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_wstrb  (d_wstrb),
      .d_rdata  (d_rdata),
      .d_done   (d_done),
      .bus_req  (bus_req),
      .bus_we   (bus_we),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb),
      .bus_ack  (bus_ack),
      .bus_rdata(bus_rdata),
      .stall_if (stall_if),
      .stall_mem(stall_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction-level reference: who owns the bus, with which command,
   // whether the fetch was abandoned, and what each requester last received.
   bit            m_busy;
   bit            m_owner_d;
   bit            m_killed;
   bit            m_clean;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [SW-1:0] m_wstrb;
   logic          m_if_done;
   logic          m_d_done;
   logic [DW-1:0] m_if_rdata;
   logic [DW-1:0] m_d_rdata;
   int unsigned   m_cnt;

   int n_vec;
   int n_miss;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy     = 1'b0;
      m_owner_d  = 1'b0;
      m_killed   = 1'b0;
      m_clean    = 1'b1;
      m_we       = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      m_wstrb    = '0;
      m_if_done  = 1'b0;
      m_d_done   = 1'b0;
      m_if_rdata = '0;
      m_d_rdata  = '0;
      m_cnt      = 0;
   endtask

   // Advance the reference by one clock using this cycle's inputs
   task automatic model_step();
      bit fetch_ok;
      bit force_i;
      if (rst) begin
         model_reset();
         return;
      end
      m_if_done = 1'b0;
      m_d_done  = 1'b0;
      if (!m_busy) begin
         fetch_ok = if_req && !if_flush;
         force_i  = GUARD && (m_cnt == SMAX) && d_req && fetch_ok;
         if (d_req && !force_i) begin
            m_busy = 1'b1; m_owner_d = 1'b1; m_clean = 1'b0;
            m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_wstrb;
            m_cnt = fetch_ok ? m_cnt + 1 : 0;
         end else if (fetch_ok) begin
            m_busy = 1'b1; m_owner_d = 1'b0; m_clean = 1'b0; m_killed = 1'b0;
            m_we = 1'b0; m_addr = if_addr; m_wstrb = '0;
            m_cnt = 0;
         end
      end else begin
         if (!m_owner_d && if_flush) m_killed = 1'b1;
         if (bus_ack) begin
            m_busy = 1'b0;
            if (m_owner_d) begin
               m_d_done  = 1'b1;
               m_d_rdata = bus_rdata;
            end else if (!m_killed) begin
               m_if_done  = 1'b1;
               m_if_rdata = bus_rdata;
            end
            m_killed = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      chk("bus_req", bus_req, m_busy);
      chk("if_done", if_done, m_if_done);
      chk("d_done", d_done, m_d_done);
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("d_rdata", d_rdata, m_d_rdata);
      chk("stall_if", stall_if, if_req && !m_if_done && !if_flush);
      chk("stall_mem", stall_mem, d_req && !m_d_done);
      if (m_busy || m_clean) begin
         chk("bus_addr", bus_addr, m_addr);
         chk("bus_we", bus_we, m_we);
         chk("bus_wstrb", bus_wstrb, m_wstrb);
         if (m_owner_d || m_clean) chk("bus_wdata", bus_wdata, m_wdata);
      end
   endtask

   // Check the current cycle, clock it, and land at the next negedge
   task automatic step();
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   logic starve_log[$];
   logic prev_req;

   initial begin
      n_vec  = 0;
      n_miss = 0;
      model_reset();
      rst = 1'b1; if_req = 1'b1; if_addr = 64'h55; if_flush = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 64'h66; d_wdata = 64'h77; d_wstrb = 8'hFF;
      bus_ack = 1'b0; bus_rdata = '0;
      @(negedge clk);
      step();
      step();

      // Reset state with idle requesters
      rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
      #1;
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_bus_addr", bus_addr, 64'h0);
      step();

      // Single fetch: ack at cycle 3, done at cycle 4
      if_req = 1'b1; if_addr = 64'h1000;
      step();
      chk("t1_req_c1", bus_req, 1'b1);
      chk("t1_addr_c1", bus_addr, 64'h1000);
      step();
      step();
      chk("t1_addr_c3", bus_addr, 64'h1000);
      bus_ack = 1'b1; bus_rdata = 64'hDEAD;
      step();
      chk("t1_done_c4", if_done, 1'b1);
      chk("t1_rdata_c4", if_rdata, 64'hDEAD);
      bus_ack = 1'b0; if_req = 1'b0;
      step();

      // Simultaneous requests: store wins, fetch follows in the done cycle
      if_req = 1'b1; if_addr = 64'h3000;
      d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2000; d_wdata = 64'h1122334455667788; d_wstrb = 8'hFF;
      step();
      #1;
      chk("t2_we_c1", bus_we, 1'b1);
      chk("t2_addr_c1", bus_addr, 64'h2000);
      chk("t2_stall_if_c1", stall_if, 1'b1);
      step();
      bus_ack = 1'b1; bus_rdata = '0;
      step();
      #1;
      chk("t2_d_done", d_done, 1'b1);
      chk("t2_stall_if_c3", stall_if, 1'b1);
      bus_ack = 1'b0; d_req = 1'b0;
      step();
      chk("t2_fetch_addr", bus_addr, 64'h3000);
      chk("t2_fetch_we", bus_we, 1'b0);
      bus_ack = 1'b1; bus_rdata = 64'hCAFE;
      step();
      chk("t2_if_done", if_done, 1'b1);
      bus_ack = 1'b0; if_req = 1'b0;
      step();

      // Flush mid-fetch: response discarded, bus_req still drops after ack
      if_req = 1'b1; if_addr = 64'h4000;
      step();
      step();
      if_flush = 1'b1;
      step();
      if_flush = 1'b0; if_req = 1'b0;
      step();
      bus_ack = 1'b1; bus_rdata = 64'hBEEF;
      step();
      chk("t3_bus_req_c5", bus_req, 1'b0);
      chk("t3_no_done", if_done, 1'b0);
      chk("t3_rdata_kept", if_rdata, 64'hCAFE);
      bus_ack = 1'b0;
      step();

      // Starvation: both held, single-cycle acks; log grant kinds from bus_we
      d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2100; d_wstrb = 8'h0F;
      if_req = 1'b1; if_addr = 64'h5100;
      prev_req = bus_req;
      for (int c = 0; c < 12; c++) begin
         bus_ack = m_busy;
         step();
         if (bus_req && !prev_req) starve_log.push_back(bus_we);
         prev_req = bus_req;
      end
      chk("t4_grants", 64'(starve_log.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < starve_log.size())
            chk($sformatf("t4_grant%0d", i), starve_log[i], GUARD ? (i % 3 != 2) : 1'b1);
      end
      d_req = 1'b0; if_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         bus_ack = m_busy;
         step();
      end
      bus_ack = 1'b0;

      // Reset during a data access; the late ack must be ignored
      d_req = 1'b1; d_we = 1'b1; d_addr = 64'h5000; d_wdata = 64'h99; d_wstrb = 8'h0F;
      step();
      step();
      rst = 1'b1;
      step();
      chk("t5_bus_req_c3", bus_req, 1'b0);
      chk("t5_d_done_c3", d_done, 1'b0);
      rst = 1'b0; bus_ack = 1'b1; d_req = 1'b0;
      step();
      chk("t5_bus_req_c4", bus_req, 1'b0);
      chk("t5_d_done_c4", d_done, 1'b0);
      bus_ack = 1'b0;
      step();

      // Randomized traffic: requesters hold until done/flush, slave acks randomly
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         if (!(d_req && !m_d_done)) begin
            d_req   = ($urandom_range(0, 1) == 1);
            d_we    = ($urandom_range(0, 1) == 1);
            d_addr  = {$urandom, $urandom};
            d_wdata = {$urandom, $urandom};
            d_wstrb = SW'($urandom);
         end
         if (!(if_req && !m_if_done && !if_flush)) begin
            if_req  = ($urandom_range(0, 1) == 1);
            if_addr = {$urandom, $urandom};
         end
         if_flush  = ($urandom_range(0, 15) == 0);
         bus_ack   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         bus_rdata = {$urandom, $urandom};
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory bus between the instruction-fetch requester (IF stage) and the data requester (MEM stage), one transaction at a time. Data has priority, with an optional anti-starvation guard for fetch. The block issues the registered bus handshake, returns read data and done pulses to the requesters, and drives the stall levels that the hazard unit folds into its pipeline stall and flush decisions. A branch flush abandons an in-flight fetch by discarding its response.

## Interface
Parameters:
- ADDR_W, 64, bus and requester address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (≥1; only used with guard)

Ports (clock: `clk`; reset: `rst`, synchronous, active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request level; held with if_addr until if_done or if_flush
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch-taken flush of fetch
- if_rdata  out  DATA_W  fetch data, valid with if_done
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request level; payload held until d_done
- d_we, d_addr, d_wdata, d_wstrb  in  1/ADDR_W/DATA_W/DATA_W/8  data command
- d_rdata  out  DATA_W  load data, valid with d_done
- d_done  out  1  one-cycle data completion pulse
- bus_req  out  1  bus request, held until bus_ack
- bus_we, bus_addr, bus_wdata, bus_wstrb  out  per above  latched command
- bus_ack  in  1  one-cycle completion from slave
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- stall_if  out  1  fetch waiting
- stall_mem  out  1  data access waiting

## Operation
- States: IDLE, BUSY_I, BUSY_D, BUSY_I_KILL.
- IDLE grant:
  - d_req, and no forced fetch: latch the data command and go to BUSY_D.
  - Otherwise if_req && !if_flush: latch if_addr with bus_we=0 and bus_wstrb=0, then go to BUSY_I.
  - if_flush in IDLE blocks the fetch grant that cycle.
- BUSY_x: bus_req=1 and the command is stable until bus_ack. On ack, register bus_rdata into if_rdata or d_rdata, pulse the matching done next cycle, and return to IDLE.
- BUSY_I with if_flush: go to BUSY_I_KILL. The bus transaction still completes, but if_done is suppressed and if_rdata is not updated. if_flush in the same cycle as bus_ack also kills.
- stall_if = if_req && !if_done && !if_flush.
- stall_mem = d_req && !d_done.
- Both stall outputs are combinational from inputs and registered done.
- Reset, including mid-transaction: state IDLE, bus_req=0, all other outputs 0, starve counter 0. The slave must tolerate an abandoned request.

## Timing
- Grant sampled in cycle 0. bus_req rises in cycle 1. With bus_ack at cycle k≥1, done is high in cycle k+1 and the FSM is IDLE in cycle k+1.
- Minimum latency is 2 cycles from request to done.
- Next grant is possible in cycle k+1, so bus_req rises again in cycle k+2.
- bus_req never asserts in IDLE; bus_ack seen in IDLE is ignored.
- Done outputs are single-cycle pulses. Requesters that still hold req in the done cycle start a new grant in that cycle.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A counter of width $clog2(STARVE_MAX+1) increments on each data grant made while if_req && !if_flush.
  - It clears on a fetch grant, or on a data grant with fetch idle.
  - When the counter equals STARVE_MAX and both requesters are pending, fetch is granted.
- Undefined: strict data priority, and no counter logic is present.

## Test plan
- Single fetch: if_addr=0x1000, if_req at cycle 0, bus_ack at cycle 3 with rdata 0xDEAD → bus_addr=0x1000 in cycles 1–3, if_done and if_rdata=0xDEAD in cycle 4.
- Simultaneous requests: if_req and d_req (store 0x2000, strobe 0xFF) in cycle 0 → data granted first; fetch granted in cycle k+1; stall_if high throughout the wait.
- Flush mid-fetch: if_flush in cycle 2 of a BUSY_I, ack in cycle 4 → no if_done and if_rdata unchanged; bus_req drops in cycle 5.
- Starvation with guard on, STARVE_MAX=2: d_req held continuously with 1-cycle acks and if_req held → grants D,D,I,D,D,I. With guard off, fetch is never granted.
- Reset in BUSY_D: rst in the cycle before bus_ack → next cycle bus_req=0, d_done=0, state IDLE, and the late bus_ack is ignored.
